// File: rtl/dl_rom_writer.sv
// Download-side ROM writer: decodes the byte-wide download stream into four
// parameterised ROM regions and reports load completion/validity for CPU hold.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no download seen since reset
// S_LOAD  | download for IDX active, bytes accepted and counted
// S_CHECK | download ended, compare byte count and unmapped flag
// S_DONE  | result latched in ROM_OK/ROM_ERR until next matching download
module dl_rom_writer #(
    parameter logic [7:0]  IDX     = 8'd0,
    parameter logic [24:0] R0_BASE = 25'h0000000,
    parameter logic [24:0] R1_BASE = 25'h0004000,
    parameter logic [24:0] R2_BASE = 25'h0008000,
    parameter logic [24:0] R3_BASE = 25'h000C000,
    parameter int unsigned R0_AW   = 14,
    parameter int unsigned R1_AW   = 14,
    parameter int unsigned R2_AW   = 14,
    parameter int unsigned R3_AW   = 14,
    parameter logic [24:0] TOTAL   = 25'h0010000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        DL_EN,
    input  logic [7:0]  DL_IDX,
    input  logic        DL_WR,
    input  logic [24:0] DL_ADDR,
    input  logic [7:0]  DL_DATA,
    output logic [15:0] ROM_AD,
    output logic [7:0]  ROM_DI,
    output logic [3:0]  ROM_WE,
    output logic        LOADING,
    output logic        ROM_OK,
    output logic        ROM_ERR,
    output logic        HOLD
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [24:0] cnt_q, cnt_d, cnt_base;
    logic        unmapped_q, unmapped_d;
    logic        armed_q, armed_d;
    logic [15:0] rom_ad_q, rom_ad_d;
    logic [7:0]  rom_di_q, rom_di_d;
    logic [3:0]  rom_we_q, rom_we_d;
    logic        loading_q, loading_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic        hold_q, hold_d;

    logic [3:0]  in_rgn;
    logic [3:0]  rgn_sel;
    logic [15:0] rgn_ad;
    logic        dl_mine;
    logic        start;
    logic        accept;
    logic        clean;

    // Limit computed one bit wider so a region ending at the top of the
    // 25-bit space does not wrap to zero.
    function automatic logic in_region(input logic [24:0] addr,
                                       input logic [24:0] base,
                                       input int unsigned aw);
        logic [25:0] limit;
        limit = {1'b0, base} + (26'd1 << aw);
        return (addr >= base) && ({1'b0, addr} < limit);
    endfunction

    function automatic logic [15:0] rel_addr(input logic [24:0] addr,
                                             input logic [24:0] base,
                                             input int unsigned aw);
        logic [24:0] diff;
        logic [24:0] mask;
        diff = addr - base;
        mask = (25'd1 << aw) - 25'd1;
        return 16'(diff & mask);
    endfunction

    assign in_rgn[0] = in_region(DL_ADDR, R0_BASE, R0_AW);
    assign in_rgn[1] = in_region(DL_ADDR, R1_BASE, R1_AW);
    assign in_rgn[2] = in_region(DL_ADDR, R2_BASE, R2_AW);
    assign in_rgn[3] = in_region(DL_ADDR, R3_BASE, R3_AW);

    // Lowest-numbered region wins on overlap, keeping ROM_WE one-hot.
    always_comb begin
        rgn_sel = 4'b0000;
        rgn_ad  = 16'h0000;
        if (in_rgn[0]) begin
            rgn_sel = 4'b0001;
            rgn_ad  = rel_addr(DL_ADDR, R0_BASE, R0_AW);
        end else if (in_rgn[1]) begin
            rgn_sel = 4'b0010;
            rgn_ad  = rel_addr(DL_ADDR, R1_BASE, R1_AW);
        end else if (in_rgn[2]) begin
            rgn_sel = 4'b0100;
            rgn_ad  = rel_addr(DL_ADDR, R2_BASE, R2_AW);
        end else if (in_rgn[3]) begin
            rgn_sel = 4'b1000;
            rgn_ad  = rel_addr(DL_ADDR, R3_BASE, R3_AW);
        end
    end

    assign dl_mine = DL_EN && (DL_IDX == IDX);
    assign start   = ((state_q == S_IDLE) || (state_q == S_DONE)) && dl_mine && armed_q;
    assign accept  = DL_WR && dl_mine && (start || (state_q == S_LOAD));
    assign clean   = (cnt_q == TOTAL) && !unmapped_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        unmapped_d = unmapped_q;
        rom_ad_d   = rom_ad_q;
        rom_di_d   = rom_di_q;
        rom_we_d   = 4'b0000;
        loading_d  = loading_q;
        ok_d       = ok_q;
        err_d      = err_q;
        armed_d    = armed_q | ~DL_EN;
        cnt_base   = start ? 25'd0 : cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    cnt_d      = 25'd0;
                    unmapped_d = 1'b0;
                    ok_d       = 1'b0;
                    err_d      = 1'b0;
                    loading_d  = 1'b1;
                end
            end
            S_LOAD: begin
                if (!DL_EN) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d   = S_DONE;
                ok_d      = clean;
                err_d     = !clean;
                loading_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            cnt_d = (&cnt_base) ? cnt_base : cnt_base + 25'd1;
            if (|rgn_sel) begin
                rom_we_d = rgn_sel;
                rom_ad_d = rgn_ad;
                rom_di_d = DL_DATA;
            end else begin
                unmapped_d = 1'b1;
            end
        end

        hold_d = loading_d | ~ok_d;
    end

    // A download already running when reset lifts must drop DL_EN before it
    // is recognised again, hence armed is loaded from ~DL_EN during reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= 25'd0;
            unmapped_q <= 1'b0;
            armed_q    <= ~DL_EN;
            rom_ad_q   <= 16'h0000;
            rom_di_q   <= 8'h00;
            rom_we_q   <= 4'b0000;
            loading_q  <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            unmapped_q <= unmapped_d;
            armed_q    <= armed_d;
            rom_ad_q   <= rom_ad_d;
            rom_di_q   <= rom_di_d;
            rom_we_q   <= rom_we_d;
            loading_q  <= loading_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
        end
    end

    assign ROM_AD  = rom_ad_q;
    assign ROM_DI  = rom_di_q;
    assign ROM_WE  = rom_we_q;
    assign LOADING = loading_q;
    assign ROM_OK  = ok_q;
    assign ROM_ERR = err_q;
    assign HOLD    = hold_q;

endmodule

// File: tb/tb_dl_rom_writer.sv
// Bench for dl_rom_writer: three instances (default map, overlapping map, small
// map) share one stimulus stream and are checked every cycle against a model.
module tb_dl_rom_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr;
    logic [7:0]  idx;
    logic [7:0]  data;
    logic [24:0] addr;

    logic [15:0] rom_ad  [3];
    logic [7:0]  rom_di  [3];
    logic [3:0]  rom_we  [3];
    logic        loading [3];
    logic        rom_ok  [3];
    logic        rom_err [3];
    logic        hold    [3];

    always #5 clk = ~clk;

    dl_rom_writer u_def (
        .CLK(clk), .RESET(rst), .DL_EN(en), .DL_IDX(idx), .DL_WR(wr),
        .DL_ADDR(addr), .DL_DATA(data),
        .ROM_AD(rom_ad[0]), .ROM_DI(rom_di[0]), .ROM_WE(rom_we[0]),
        .LOADING(loading[0]), .ROM_OK(rom_ok[0]), .ROM_ERR(rom_err[0]), .HOLD(hold[0])
    );

    dl_rom_writer #(.R1_BASE(25'h3000)) u_ovl (
        .CLK(clk), .RESET(rst), .DL_EN(en), .DL_IDX(idx), .DL_WR(wr),
        .DL_ADDR(addr), .DL_DATA(data),
        .ROM_AD(rom_ad[1]), .ROM_DI(rom_di[1]), .ROM_WE(rom_we[1]),
        .LOADING(loading[1]), .ROM_OK(rom_ok[1]), .ROM_ERR(rom_err[1]), .HOLD(hold[1])
    );

    dl_rom_writer #(
        .R0_BASE(25'h00), .R1_BASE(25'h30), .R2_BASE(25'h80), .R3_BASE(25'hC0),
        .R0_AW(6), .R1_AW(7), .R2_AW(6), .R3_AW(6), .TOTAL(25'h100)
    ) u_small (
        .CLK(clk), .RESET(rst), .DL_EN(en), .DL_IDX(idx), .DL_WR(wr),
        .DL_ADDR(addr), .DL_DATA(data),
        .ROM_AD(rom_ad[2]), .ROM_DI(rom_di[2]), .ROM_WE(rom_we[2]),
        .LOADING(loading[2]), .ROM_OK(rom_ok[2]), .ROM_ERR(rom_err[2]), .HOLD(hold[2])
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: per-instance region map and download bookkeeping.
    longint    m_base  [3][4];
    int        m_aw    [3][4];
    longint    m_total [3];
    bit        m_busy [3], m_closing [3], m_loading [3], m_ok [3], m_err [3];
    bit        m_hold [3], m_unm [3], m_armed [3];
    longint    m_cnt  [3];
    bit [3:0]  m_we   [3];
    bit [15:0] m_ad   [3];
    bit [7:0]  m_di   [3];

    bit        count_on = 1'b0;
    int        pulses [4];

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [3:0]  we0, we1, we2;
        logic [15:0] ad0, ad1, ad2;
    } vec_t;
    vec_t tbl [14];

    task automatic summary();
        $display("%0d/%0d checks passed", n_pass, n_total);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
            if (n_total - n_pass >= 500) begin
                summary();
                $finish;
            end
        end
    endtask

    function automatic logic [31:0] obs(input int k);
        return {rom_we[k], rom_ad[k], rom_di[k], loading[k], rom_ok[k], rom_err[k], hold[k]};
    endfunction

    function automatic logic [31:0] expect_vec(input int k);
        return {m_we[k], m_ad[k], m_di[k], m_loading[k], m_ok[k], m_err[k], m_hold[k]};
    endfunction

    task automatic take_byte(input int k);
        bit found;
        longint a, span;
        found = 1'b0;
        a = longint'(addr);
        if (m_cnt[k] < 64'd33554431) m_cnt[k] = m_cnt[k] + 1;
        for (int n = 0; n < 4; n++) begin
            span = longint'(1) << m_aw[k][n];
            if (!found && a >= m_base[k][n] && a < m_base[k][n] + span) begin
                found   = 1'b1;
                m_we[k] = 4'(1 << n);
                m_ad[k] = 16'((a - m_base[k][n]) % span);
                m_di[k] = data;
            end
        end
        if (!found) m_unm[k] = 1'b1;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_busy[k] = 0; m_closing[k] = 0; m_loading[k] = 0; m_ok[k] = 0;
                m_err[k] = 0; m_unm[k] = 0; m_cnt[k] = 0; m_hold[k] = 1;
                m_we[k] = '0; m_ad[k] = '0; m_di[k] = '0; m_armed[k] = !en;
            end else begin
                m_we[k] = '0;
                if (m_closing[k]) begin
                    m_ok[k]      = (m_cnt[k] == m_total[k]) && !m_unm[k];
                    m_err[k]     = !m_ok[k];
                    m_loading[k] = 0;
                    m_closing[k] = 0;
                end else if (m_busy[k]) begin
                    if (!en) begin
                        m_busy[k]    = 0;
                        m_closing[k] = 1;
                    end else if (wr && idx == 8'd0) begin
                        take_byte(k);
                    end
                end else if (en && idx == 8'd0 && m_armed[k]) begin
                    m_busy[k] = 1; m_loading[k] = 1; m_cnt[k] = 0;
                    m_unm[k] = 0; m_ok[k] = 0; m_err[k] = 0;
                    if (wr) take_byte(k);
                end
                if (!en) m_armed[k] = 1;
                m_hold[k] = m_loading[k] | !m_ok[k];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("model inst%0d t=%0t", k, $time), obs(k), expect_vec(k));
        if (count_on)
            for (int n = 0; n < 4; n++)
                if (rom_we[0][n]) pulses[n]++;
    endtask

    task automatic close_dl();
        wr = 0; en = 0;
        repeat (3) tick();
    endtask

    task automatic small_dl(input int n, input bit extra);
        en = 1; idx = 0;
        for (int a = 0; a < n; a++) begin
            wr = 1; addr = 25'(a); data = 8'($urandom);
            tick();
        end
        if (extra) begin
            wr = 1; addr = 25'h10000; data = 8'hEE;
            tick();
            check("extra byte WE", {28'd0, rom_we[2]}, 32'd0);
        end
        close_dl();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_total[k] = (k == 2) ? 64'h100 : 64'h10000;
            for (int n = 0; n < 4; n++) begin
                m_base[k][n] = longint'(n) * 64'h4000;
                m_aw[k][n]   = 14;
            end
        end
        m_base[1][1] = 64'h3000;
        m_base[2][0] = 64'h00; m_base[2][1] = 64'h30; m_base[2][2] = 64'h80; m_base[2][3] = 64'hC0;
        m_aw[2][0] = 6; m_aw[2][1] = 7; m_aw[2][2] = 6; m_aw[2][3] = 6;

        tbl[0]  = '{25'h0000000, 8'h5A, 4'b0001, 4'b0001, 4'b0001, 16'h0000, 16'h0000, 16'h0000};
        tbl[1]  = '{25'h0003004, 8'hA5, 4'b0001, 4'b0001, 4'b0000, 16'h3004, 16'h3004, 16'h0000};
        tbl[2]  = '{25'h0004001, 8'h01, 4'b0010, 4'b0010, 4'b0000, 16'h0001, 16'h1001, 16'h0000};
        tbl[3]  = '{25'h0007000, 8'h77, 4'b0010, 4'b0000, 4'b0000, 16'h3000, 16'h0000, 16'h0000};
        tbl[4]  = '{25'h0000034, 8'h34, 4'b0001, 4'b0001, 4'b0001, 16'h0034, 16'h0034, 16'h0034};
        tbl[5]  = '{25'h000003F, 8'h3F, 4'b0001, 4'b0001, 4'b0001, 16'h003F, 16'h003F, 16'h003F};
        tbl[6]  = '{25'h0000040, 8'h40, 4'b0001, 4'b0001, 4'b0010, 16'h0040, 16'h0040, 16'h0010};
        tbl[7]  = '{25'h00000B0, 8'hB0, 4'b0001, 4'b0001, 4'b0100, 16'h00B0, 16'h00B0, 16'h0030};
        tbl[8]  = '{25'h00000AF, 8'hAF, 4'b0001, 4'b0001, 4'b0010, 16'h00AF, 16'h00AF, 16'h007F};
        tbl[9]  = '{25'h000FFFF, 8'hFF, 4'b1000, 4'b1000, 4'b0000, 16'h3FFF, 16'h3FFF, 16'h0000};
        tbl[10] = '{25'h0010000, 8'h10, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[11] = '{25'h1FFFFFF, 8'hEE, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[12] = '{25'h00000C5, 8'hC5, 4'b0001, 4'b0001, 4'b1000, 16'h00C5, 16'h00C5, 16'h0005};
        tbl[13] = '{25'h000BFFF, 8'hBF, 4'b0100, 4'b0100, 4'b0000, 16'h3FFF, 16'h3FFF, 16'h0000};

        rst = 1; en = 0; wr = 0; idx = 0; addr = '0; data = '0;
        tick();
        check("reset values inst0", obs(0), {4'b0000, 16'h0000, 8'h00, 4'b0001});
        repeat (2) tick();
        rst = 0;
        repeat (2) tick();

        // Full default download, one byte per cycle, first byte on the start cycle.
        for (int n = 0; n < 4; n++) pulses[n] = 0;
        count_on = 1; en = 1; idx = 0;
        for (int a = 0; a < 65536; a++) begin
            wr = 1; addr = 25'(a); data = 8'(a);
            tick();
            if (a == 'h4001)
                check("byte 4001 write", {4'd0, rom_we[0], rom_ad[0], rom_di[0]},
                      {4'd0, 4'b0010, 16'h0001, 8'h01});
        end
        close_dl();
        count_on = 0;
        for (int n = 0; n < 4; n++)
            check($sformatf("region %0d pulses", n), 32'(pulses[n]), 32'd16384);
        check("full flags ok/err/hold", {29'd0, rom_ok[0], rom_err[0], hold[0]}, 32'b100);

        // Foreign-index download must leave everything untouched.
        en = 1; idx = 8'd1;
        for (int i = 0; i < 20; i++) begin
            wr = 1; addr = 25'($urandom_range(0, 'hFFFF)); data = 8'($urandom);
            tick();
            check("foreign idx we/loading/ok", {27'd0, rom_we[0], loading[0]}, {27'd0, 4'b0000, 1'b0});
            check("foreign idx ok held", {31'd0, rom_ok[0]}, 32'd1);
        end
        close_dl();
        idx = 0;
        check("foreign idx final ok", {29'd0, rom_ok[0], rom_err[0], hold[0]}, 32'b100);

        // Table of single-byte decode cases across the three maps.
        en = 1;
        for (int i = 0; i < 14; i++) begin
            logic [3:0]  ew [3];
            logic [15:0] ea [3];
            ew[0] = tbl[i].we0; ew[1] = tbl[i].we1; ew[2] = tbl[i].we2;
            ea[0] = tbl[i].ad0; ea[1] = tbl[i].ad1; ea[2] = tbl[i].ad2;
            wr = 1; addr = tbl[i].addr; data = tbl[i].data;
            tick();
            for (int k = 0; k < 3; k++) begin
                if (ew[k] != 4'b0000)
                    check($sformatf("table %0d inst%0d", i, k),
                          {4'd0, rom_we[k], rom_ad[k], rom_di[k]}, {4'd0, ew[k], ea[k], tbl[i].data});
                else
                    check($sformatf("table %0d inst%0d no-we", i, k), {28'd0, rom_we[k]}, 32'd0);
            end
        end
        close_dl();

        small_dl('h100, 0);
        check("small full flags", {29'd0, rom_ok[2], rom_err[2], hold[2]}, 32'b100);
        small_dl('hFF, 0);
        check("small short flags", {29'd0, rom_ok[2], rom_err[2], hold[2]}, 32'b011);
        small_dl('h100, 1);
        check("small long count", 32'(u_small.cnt_q), 32'h101);
        check("small long flags", {29'd0, rom_ok[2], rom_err[2], hold[2]}, 32'b011);

        // Reset pulse in the middle of a download with a strobe present.
        en = 1;
        for (int a = 0; a < 'h40; a++) begin
            wr = 1; addr = 25'(a); data = 8'(a);
            tick();
        end
        rst = 1; wr = 1; addr = 25'h40; data = 8'h40;
        tick();
        for (int k = 0; k < 3; k++)
            check($sformatf("mid-load reset inst%0d", k), obs(k), {4'b0000, 16'h0000, 8'h00, 4'b0001});
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            wr = 1; addr = 25'('h41 + i); data = 8'(i);
            tick();
            check("post-reset strobe ignored", {27'd0, rom_we[2], loading[2]}, 32'd0);
        end
        wr = 0; en = 0;
        repeat (2) tick();
        small_dl('h100, 0);
        check("post-reset full ok", {29'd0, rom_ok[2], rom_err[2], hold[2]}, 32'b100);

        // Randomised episodes against the model.
        for (int ep = 0; ep < 25; ep++) begin
            int mode, n;
            idx  = ($urandom_range(0, 4) == 0) ? 8'd1 : 8'd0;
            en   = 1;
            mode = $urandom_range(0, 3);
            n    = (mode == 0) ? 'h100 : (mode == 1) ? 'hFF : (mode == 2) ? 'h101 : $urandom_range(1, 300);
            for (int i = 0; i < n; i++) begin
                while ($urandom_range(0, 3) == 0) begin
                    wr = 0;
                    tick();
                end
                wr   = 1;
                addr = (mode < 3) ? 25'(i) : 25'($urandom_range(0, 'h1FFFF));
                data = 8'($urandom);
                rst  = ($urandom_range(0, 999) == 0);
                tick();
                rst  = 0;
            end
            en = 0;
            for (int g = 0; g < $urandom_range(1, 4); g++) begin
                wr = 1'($urandom_range(0, 1));
                tick();
            end
        end
        wr = 0; en = 0; idx = 0;
        repeat (4) tick();

        summary();
        $finish;
    end

endmodule

// File: doc/dl_rom_writer.md
# dl_rom_writer

Download-side writer for the design's loadable ROM blocks. Consumes the framework's byte-wide ROM download stream, decodes each byte address against four parameterised regions, and drives the write port (address, data, one-hot write enable) of the matching ROM. It also:

- counts accepted bytes;
- flags out-of-map traffic;
- reports load completion and validity, so the top level can hold the game CPUs in reset until the ROM set is good.

## Interface

Parameters:
- `IDX`, 8'd0: download index that selects this writer.
- `R0_BASE`..`R3_BASE`, 0 / 'h4000 / 'h8000 / 'hC000: 25-bit byte base address of region n.
- `R0_AW`..`R3_AW`, 14: address width of region n; the region spans 2**AW bytes, AW ≤ 16.
- `TOTAL`, 'h10000: expected byte count of a complete download.

Ports:
- `CLK` in 1: single clock for all logic.
- `RESET` in 1: synchronous, active-high reset.
- `DL_EN` in 1: download active.
- `DL_IDX` in 8: index of the current download.
- `DL_WR` in 1: byte strobe, one cycle per byte.
- `DL_ADDR` in 25: byte address.
- `DL_DATA` in 8: byte data.
- `ROM_AD` out 16: region-relative write address; bits above the region's AW are 0.
- `ROM_DI` out 8: write data.
- `ROM_WE` out 4: one-hot write enable; bit n targets region n.
- `LOADING` out 1: download for `IDX` in progress.
- `ROM_OK` out 1: last download complete and clean.
- `ROM_ERR` out 1: last download short, long, or out of map.
- `HOLD` out 1: `LOADING | ~ROM_OK`, registered; drives the CPU reset request.

## Operation

State machine: IDLE, LOAD, CHECK, DONE.
- IDLE / DONE → LOAD when `DL_EN` = 1 and `DL_IDX` = `IDX`.
  - On entry to LOAD: clear the byte counter, the unmapped flag, `ROM_OK` and `ROM_ERR`.
  - Set `LOADING` = 1.
- LOAD → CHECK on the first cycle `DL_EN` = 0.
- CHECK → DONE after one cycle.
  - `ROM_OK` = (count == `TOTAL`) & ~unmapped.
  - `ROM_ERR` = ~`ROM_OK`.
  - `LOADING` = 0.
- DONE holds until a new matching download starts. A new download from DONE restarts fully and drops `ROM_OK` on entry.
- A download with a different `DL_IDX` is ignored entirely. There are no state, flag or `ROM_WE` changes, including while in DONE.

Byte acceptance:
- A byte is accepted when `DL_WR` & `DL_EN` & (`DL_IDX` == `IDX`) while in IDLE-transition or LOAD.
- A `DL_WR` in the same cycle as the IDLE→LOAD decision is accepted.
- `DL_WR` with `DL_EN` = 0 is ignored.

Region decode:
- Region n matches when `Rn_BASE` ≤ `DL_ADDR` < `Rn_BASE` + 2**`Rn_AW`.
- Overlapping regions: the lowest n wins, so `ROM_WE` is always one-hot or zero.
- The subtraction uses full 25-bit width, with no wrap.

Accepted byte:
- Counter increments; 25-bit, saturates at all-ones.
- If a region matches: `ROM_AD` = `DL_ADDR` − `Rn_BASE` (truncated to AW, zero-extended), `ROM_DI` = `DL_DATA`, `ROM_WE`[n] = 1.
- If no region matches: `ROM_WE` = 0 and the unmapped flag is set.

`ROM_AD` and `ROM_DI` hold their last values when `ROM_WE` = 0.

## Timing

- Reset values: state IDLE, `ROM_AD` = 0, `ROM_DI` = 0, `ROM_WE` = 0, `LOADING` = 0, `ROM_OK` = 0, `ROM_ERR` = 0, `HOLD` = 1, counter 0, unmapped flag 0.
- Write latency is exactly 1 cycle: a `DL_WR` sampled at edge k gives `ROM_AD`/`ROM_DI`/`ROM_WE` valid from edge k to edge k+1.
- `ROM_WE` is high for exactly one cycle per accepted mapped byte.
- Back-to-back `DL_WR` on consecutive cycles is supported at full rate. There is no stall output.
- `DL_EN` falling: a byte accepted on the last `DL_EN` = 1 cycle is counted before CHECK evaluates.
  - `ROM_OK`/`ROM_ERR` update 2 edges after `DL_EN` is first sampled low: the edge that sees `DL_EN` low enters CHECK, and the CHECK edge updates the flags.
  - `LOADING` falls on that same edge.
- `HOLD` is registered from next-state values, so it tracks `LOADING`/`ROM_OK` on the same edge.
- `RESET` mid-load: all outputs are at reset values on the following edge, and `ROM_WE` is 0 on that edge even if `DL_WR` is high. The download is abandoned; a fresh `DL_EN` rising with matching index is required before it is recognised again, i.e. `DL_EN` still high after reset does not re-enter LOAD.

## Test plan

- Defaults; stream 65536 bytes at addr 0..'hFFFF, data = addr[7:0], one per cycle, index 0.
  - Required: 16384 `ROM_WE`[n] pulses per region.
  - Byte 'h4001 gives `ROM_WE` = 4'b0010, `ROM_AD` = 1, `ROM_DI` = 'h01, one cycle after its strobe.
  - Final flags: `ROM_OK` = 1, `ROM_ERR` = 0, `HOLD` = 0.
- Stream 'hFFFF bytes (one short).
  - Required: `ROM_ERR` = 1, `ROM_OK` = 0, `HOLD` = 1.
- Full stream plus one byte at addr 'h10000.
  - Required: no `ROM_WE` for that byte, count 'h10001, `ROM_ERR` = 1.
- Download with `DL_IDX` = 1 after a good load.
  - Required: `ROM_WE` stays 0, `ROM_OK` stays 1, `LOADING` stays 0.
- Set `R1_BASE` = 'h3000 (overlaps region 0); write addr 'h3004.
  - Required: `ROM_WE` = 4'b0001, `ROM_AD` = 'h3004.
- Assert `RESET` for 1 cycle mid-stream with `DL_WR` high.
  - Required: `ROM_WE` = 0 that edge, `LOADING` = 0, `HOLD` = 1, later strobes ignored until `DL_EN` re-rises.
  - Required: a subsequent full download gives `ROM_OK` = 1.
